// File: rtl/lck_ampl_pkg.sv
`default_nettype none
// lck_ampl_pkg: widths, FSM states and config field offsets shared by the lock-in amplitude block.
// Revision 1.0
package lck_ampl_pkg;

  localparam int A2_WIDTH_DEF   = 48;
  localparam int ROOT_WIDTH_DEF = 24;
  localparam int FRAC_WIDTH_DEF = 16;

  localparam int CFG_EN_BIT  = 0;
  localparam int CFG_CLR_BIT = 1;
  localparam int CFG_K_LSB   = 8;
  localparam int CFG_K_MSB   = 12;
  localparam int K_WIDTH     = CFG_K_MSB - CFG_K_LSB + 1;

  localparam logic [K_WIDTH-1:0] K_MAX = K_WIDTH'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FILT = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic logic [K_WIDTH-1:0] clamp_k(input logic [K_WIDTH-1:0] k);
    return (k > K_MAX) ? K_MAX : k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lck_isqrt_iter.sv
`default_nettype none
// lck_isqrt_iter: restoring digit-by-digit integer square root, two operand bits per cycle.
// Revision 1.0
module lck_isqrt_iter #(
  parameter int A2_WIDTH   = 48,
  parameter int ROOT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [A2_WIDTH-1:0]   operand,
  output logic                  done,
  output logic [ROOT_WIDTH-1:0] root
);

  localparam int CNT_W = $clog2(ROOT_WIDTH);

  logic                  running;
  logic [CNT_W-1:0]      step;
  logic [A2_WIDTH-1:0]   op;
  logic [ROOT_WIDTH+1:0] rem;
  logic [ROOT_WIDTH+1:0] rem_sh;
  logic [ROOT_WIDTH+1:0] trial;
  logic                  fits;

  // Remainder never exceeds 2*root before the last step, so the shift cannot lose bits.
  always_comb begin
    rem_sh = (rem << 2) | {{ROOT_WIDTH{1'b0}}, op[A2_WIDTH-1 -: 2]};
    trial  = {root, 2'b01};
    fits   = (rem_sh >= trial);
  end

  // High during the final iteration, so the caller can leave CALC on the same edge.
  assign done = running && (step == CNT_W'(ROOT_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      step    <= '0;
      op      <= '0;
      rem     <= '0;
      root    <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
      op      <= operand;
      rem     <= '0;
      root    <= '0;
    end else if (running) begin
      op   <= op << 2;
      rem  <= fits ? (rem_sh - trial) : rem_sh;
      root <= {root[ROOT_WIDTH-2:0], fits};
      step <= step + CNT_W'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_lck_amplitude.sv
`default_nettype none
// axis_lck_amplitude: sqrt of lock-in |A|^2 followed by a configurable first-order IIR smoother.
// Revision 1.0
module axis_lck_amplitude
  import lck_ampl_pkg::*;
#(
  parameter int A2_WIDTH              = A2_WIDTH_DEF,
  parameter int ROOT_WIDTH            = ROOT_WIDTH_DEF,
  parameter int FRAC_WIDTH            = FRAC_WIDTH_DEF,
  parameter int configuration_address = 1000
) (
  input  logic                a_clk,
  input  logic                a_reset,
  input  logic [31:0]         config_addr,
  input  logic [511:0]        config_data,
  input  logic [A2_WIDTH-1:0] S_AXIS_A2_tdata,
  input  logic                S_AXIS_A2_tvalid,
  input  logic                deci_clk,
  output logic [31:0]         M_AXIS_AMPL_tdata,
  output logic                M_AXIS_AMPL_tvalid,
  output logic [31:0]         M_AXIS_RAW_tdata,
  output logic                busy,
  output logic [15:0]         overrun_count
);

  localparam int ACC_W = ROOT_WIDTH + FRAC_WIDTH;

  state_t                state;
  logic                  deci_prev;
  logic                  trig;
  logic                  drop;
  logic                  start;
  logic                  cfg_hit;
  logic                  clr;
  logic                  enable;
  logic                  primed;
  logic [K_WIDTH-1:0]    k;
  logic                  sqrt_done;
  logic [ROOT_WIDTH-1:0] root;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_next;
  logic [ACC_W-1:0]      target;
  logic signed [ACC_W:0] diff;
  logic signed [ACC_W:0] delta;
  logic signed [ACC_W:0] sum;
  logic                  unused_inputs;

  assign trig    = deci_clk & ~deci_prev;
  assign start   = trig && (state == IDLE);
  assign drop    = trig && (state != IDLE);
  assign cfg_hit = (config_addr == 32'(configuration_address));
  assign clr     = cfg_hit && config_data[CFG_CLR_BIT];
  assign busy    = (state != IDLE);

  assign unused_inputs = ^{config_data[511:CFG_K_MSB+1], config_data[CFG_K_LSB-1:CFG_CLR_BIT+1],
                           S_AXIS_A2_tvalid};

  lck_isqrt_iter #(
    .A2_WIDTH   (A2_WIDTH),
    .ROOT_WIDTH (ROOT_WIDTH)
  ) u_isqrt (
    .clk     (a_clk),
    .rst     (a_reset),
    .start   (start),
    .operand (S_AXIS_A2_tdata),
    .done    (sqrt_done),
    .root    (root)
  );

  // Difference is signed so a falling amplitude decays with an arithmetic shift.
  always_comb begin
    target = ACC_W'(root) << FRAC_WIDTH;
    diff   = $signed({1'b0, target}) - $signed({1'b0, acc});
    delta  = diff >>> k;
    sum    = $signed({1'b0, acc}) + delta;
    if (!enable || (k == '0) || !primed) begin
      acc_next = target;
    end else begin
      acc_next = ACC_W'(sum);
    end
  end

  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      state              <= IDLE;
      deci_prev          <= 1'b0;
      enable             <= 1'b0;
      primed             <= 1'b0;
      k                  <= '0;
      acc                <= '0;
      overrun_count      <= '0;
      M_AXIS_AMPL_tdata  <= '0;
      M_AXIS_AMPL_tvalid <= 1'b0;
      M_AXIS_RAW_tdata   <= '0;
    end else begin
      deci_prev          <= deci_clk;
      M_AXIS_AMPL_tvalid <= 1'b0;

      if (cfg_hit) begin
        enable <= config_data[CFG_EN_BIT];
        k      <= clamp_k(config_data[CFG_K_MSB:CFG_K_LSB]);
      end

      if (clr) begin
        overrun_count <= drop ? 16'd1 : 16'd0;
      end else if (drop && (overrun_count != 16'hFFFF)) begin
        overrun_count <= overrun_count + 16'd1;
      end

      // Any cycle spent disabled forces a preload on the next filter update.
      if (state == FILT) begin
        primed <= enable;
      end else if (!enable) begin
        primed <= 1'b0;
      end

      case (state)
        IDLE: if (trig) state <= CALC;
        CALC: if (sqrt_done) state <= FILT;
        FILT: begin
          acc   <= acc_next;
          state <= OUT;
        end
        OUT: begin
          M_AXIS_AMPL_tdata  <= 32'(acc >> FRAC_WIDTH);
          M_AXIS_RAW_tdata   <= 32'(root);
          M_AXIS_AMPL_tvalid <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_lck_amplitude.sv
`default_nettype none
// tb_axis_lck_amplitude: directed + random checks against an arithmetic reference model.
module tb_axis_lck_amplitude;

  logic         a_clk = 1'b0;
  logic         a_reset;
  logic [31:0]  config_addr;
  logic [511:0] config_data;
  logic [47:0]  S_AXIS_A2_tdata;
  logic         S_AXIS_A2_tvalid;
  logic         deci_clk;
  logic [31:0]  M_AXIS_AMPL_tdata;
  logic         M_AXIS_AMPL_tvalid;
  logic [31:0]  M_AXIS_RAW_tdata;
  logic         busy;
  logic [15:0]  overrun_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference filter state
  bit     m_en;
  int     m_k;
  bit     m_primed;
  longint m_acc;

  always #5 a_clk = ~a_clk;

  axis_lck_amplitude dut (
    .a_clk              (a_clk),
    .a_reset            (a_reset),
    .config_addr        (config_addr),
    .config_data        (config_data),
    .S_AXIS_A2_tdata    (S_AXIS_A2_tdata),
    .S_AXIS_A2_tvalid   (S_AXIS_A2_tvalid),
    .deci_clk           (deci_clk),
    .M_AXIS_AMPL_tdata  (M_AXIS_AMPL_tdata),
    .M_AXIS_AMPL_tvalid (M_AXIS_AMPL_tvalid),
    .M_AXIS_RAW_tdata   (M_AXIS_RAW_tdata),
    .busy               (busy),
    .overrun_count      (overrun_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint a);
    longint r;
    r = longint'($sqrt(real'(a)));
    while (r * r > a) r--;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic model_filt(input longint r, output longint amp);
    longint tgt;
    tgt = r * 65536;
    if (!m_en || m_k == 0 || !m_primed) m_acc = tgt;
    else m_acc = m_acc + ((tgt - m_acc) >>> m_k);
    m_primed = m_en;
    amp = m_acc / 65536;
  endtask

  function automatic longint rnd48();
    longint v;
    v = {$urandom, $urandom};
    return v & 64'h0000_FFFF_FFFF_FFFF;
  endfunction

  task automatic set_cfg(input bit en, input int kk, input bit clr);
    logic [4:0] kf;
    kf = kk[4:0];
    config_addr       = 32'd1000;
    config_data       = '0;
    config_data[0]    = en;
    config_data[1]    = clr;
    config_data[12:8] = kf;
    @(negedge a_clk);
    config_addr = '0;
    config_data = '0;
    m_en = en;
    m_k  = (kf > 5'd16) ? 16 : int'(kf);
    if (!en) m_primed = 1'b0;
  endtask

  // Caller is at a negedge; trigger is sampled on the following posedge.
  task automatic run(input string tag, input longint a2);
    int     lat;
    longint er, ea;
    logic [63:0] a2v;
    a2v = a2;
    S_AXIS_A2_tdata  = a2v[47:0];
    S_AXIS_A2_tvalid = 1'b1;
    deci_clk         = 1'b1;
    @(negedge a_clk);
    deci_clk         = 1'b0;
    S_AXIS_A2_tvalid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge a_clk);
      if (i == 1) check({tag, "_busy"}, busy, 1);
      if (M_AXIS_AMPL_tvalid) begin
        lat = i;
        break;
      end
    end
    er = isqrt(a2);
    model_filt(er, ea);
    check({tag, "_lat"}, lat, 26);
    check({tag, "_raw"}, M_AXIS_RAW_tdata, er);
    check({tag, "_ampl"}, M_AXIS_AMPL_tdata, ea);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a, dummy;
    int     seen;

    a_reset = 1'b1; config_addr = '0; config_data = '0;
    S_AXIS_A2_tdata = '0; S_AXIS_A2_tvalid = 1'b0; deci_clk = 1'b0;
    m_en = 1'b0; m_k = 0; m_primed = 1'b0; m_acc = 0;
    repeat (3) @(negedge a_clk);
    check("rst_ampl", M_AXIS_AMPL_tdata, 0);
    check("rst_raw", M_AXIS_RAW_tdata, 0);
    check("rst_tvalid", M_AXIS_AMPL_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun_count, 0);
    a_reset = 1'b0;
    @(negedge a_clk);

    run("zero", 0);
    @(negedge a_clk);
    check("tvalid_pulse_width", M_AXIS_AMPL_tvalid, 0);
    check("hold_raw", M_AXIS_RAW_tdata, 0);
    run("max", 64'h0000_FFFF_FFFF_FFFF);
    run("1e6", 1000000);
    run("999999", 999999);
    for (int i = 0; i < 6; i++) run("rnd", rnd48());
    check("b2b_no_ovr", overrun_count, 0);

    // second trigger ten cycles into a computation
    a = 64'd12345678901;
    S_AXIS_A2_tdata = a[47:0]; deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    repeat (9) @(negedge a_clk);
    S_AXIS_A2_tdata = 48'd7; deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    repeat (16) @(negedge a_clk);
    model_filt(isqrt(a), dummy);
    check("ovr_tvalid", M_AXIS_AMPL_tvalid, 1);
    check("ovr_raw", M_AXIS_RAW_tdata, isqrt(a));
    check("ovr_count", overrun_count, 1);

    // clear coinciding with a drop leaves exactly one
    a = 64'd4000000;
    S_AXIS_A2_tdata = a[47:0]; deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    repeat (4) @(negedge a_clk);
    deci_clk = 1'b1; config_addr = 32'd1000; config_data = '0; config_data[1] = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0; config_addr = '0; config_data = '0;
    check("clr_drop_count", overrun_count, 1);
    repeat (21) @(negedge a_clk);
    model_filt(isqrt(a), dummy);
    check("clr_drop_raw", M_AXIS_RAW_tdata, 2000);
    set_cfg(1'b0, 0, 1'b1);
    check("clr_count", overrun_count, 0);

    // trigger landing in the OUT cycle is dropped
    a = 64'd81;
    S_AXIS_A2_tdata = a[47:0]; deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    repeat (25) @(negedge a_clk);
    deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    model_filt(isqrt(a), dummy);
    check("out_trig_tvalid", M_AXIS_AMPL_tvalid, 1);
    check("out_trig_raw", M_AXIS_RAW_tdata, 9);
    check("out_trig_ovr", overrun_count, 1);
    @(negedge a_clk);
    check("out_trig_idle", busy, 0);
    set_cfg(1'b0, 0, 1'b1);

    // write to another address is ignored
    config_addr = 32'd999; config_data = '0; config_data[0] = 1'b1; config_data[12:8] = 5'd2;
    @(negedge a_clk); config_addr = '0; config_data = '0;
    run("wrong_addr", 250000);

    // IIR smoothing, k=1
    set_cfg(1'b1, 1, 1'b0);
    run("k1_a", 1000000);
    run("k1_b", 0);
    run("k1_c", 0);
    check("k1_final", M_AXIS_AMPL_tdata, 250);

    for (int i = 0; i < 6; i++) begin
      set_cfg(1'b1, int'($urandom_range(0, 20)), 1'b0);
      run("filt_rnd1", longint'($urandom) * 64);
      run("filt_rnd2", longint'($urandom));
    end
    set_cfg(1'b0, 3, 1'b0);
    set_cfg(1'b1, 3, 1'b0);
    run("repreload", 90000);
    run("after_preload", 10000);

    // reset in the middle of CALC
    a = 64'd1000000;
    S_AXIS_A2_tdata = a[47:0]; deci_clk = 1'b1;
    @(negedge a_clk); deci_clk = 1'b0;
    repeat (11) @(negedge a_clk);
    a_reset = 1'b1;
    #1;
    check("midrst_ampl", M_AXIS_AMPL_tdata, 0);
    check("midrst_raw", M_AXIS_RAW_tdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovr", overrun_count, 0);
    @(negedge a_clk);
    a_reset = 1'b0;
    m_en = 1'b0; m_k = 0; m_primed = 1'b0; m_acc = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge a_clk);
      if (M_AXIS_AMPL_tvalid) seen++;
    end
    check("midrst_no_tvalid", seen, 0);
    run("post_rst", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_lck_amplitude.md
AXIS_LCK_AMPLITUDE -- requirements
Module: axis_lck_amplitude

Interface
REQ-001 SHALL have parameter A2_WIDTH, default 48: width of the squared-amplitude input.
REQ-002 SHALL have parameter ROOT_WIDTH, default 24 (= A2_WIDTH/2): width of the square-root result.
REQ-003 SHALL have parameter FRAC_WIDTH, default 16: fractional bits of the IIR accumulator.
REQ-004 SHALL have parameter configuration_address, default 1000: config bus address decoded by this block.
REQ-005 SHALL have port a_clk, input, 1: the single clock.
REQ-006 SHALL have port a_reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports config_addr (input, 32) and config_data (input, 512); fields: bit0 filter enable, bits[12:8] shift k (0..16), bit1 overrun-clear strobe.
REQ-008 SHALL have port S_AXIS_A2_tdata, input, A2_WIDTH: unsigned amplitude squared from the lock-in.
REQ-009 SHALL have port S_AXIS_A2_tvalid, input, 1: accepted but ignored.
REQ-010 SHALL have port deci_clk, input, 1: lock-in result strobe (axis_deci_clk).
REQ-011 SHALL have port M_AXIS_AMPL_tdata, output, 32: filtered amplitude, zero-extended.
REQ-012 SHALL have port M_AXIS_AMPL_tvalid, output, 1: one-cycle pulse per new result.
REQ-013 SHALL have port M_AXIS_RAW_tdata, output, 32: unfiltered floor(sqrt), zero-extended.
REQ-014 SHALL have port busy, output, 1: high when the FSM is not in IDLE.
REQ-015 SHALL have port overrun_count, output, 16: count of dropped triggers, saturating.

Function
REQ-016 Trigger SHALL be the cycle T where deci_clk=1 and the registered previous deci_clk=0.
REQ-017 At T in IDLE, the block SHALL capture S_AXIS_A2_tdata, clear root/remainder, and enter CALC at T+1.
REQ-018 CALC SHALL run ROOT_WIDTH cycles (T+1..T+24), consuming 2 operand bits per cycle (digit-by-digit restoring), yielding exact floor(sqrt(A2)).
REQ-019 FILT (T+25) SHALL update the filter: if enable=0 or k=0, acc = root<<FRAC_WIDTH; else acc = acc + ((root<<FRAC_WIDTH) - acc) >>> k, with a signed difference.
REQ-020 The first FILT after enable goes 0->1 SHALL preload acc = root<<FRAC_WIDTH.
REQ-021 OUT (T+26) SHALL register M_AXIS_AMPL_tdata = acc>>FRAC_WIDTH and M_AXIS_RAW_tdata = root, pulse tvalid, and return to IDLE at T+27.
REQ-022 Latency SHALL be fixed: the tvalid pulse is 26 cycles after the trigger; outputs hold until the next OUT.
REQ-023 A trigger when not IDLE SHALL be dropped and SHALL increment overrun_count (saturating at 0xFFFF); the current computation SHALL be unaffected.
REQ-024 Overrun-clear SHALL zero overrun_count; if a drop occurs in the same cycle, the count SHALL become 1.
REQ-025 Config fields SHALL latch when config_addr==configuration_address; k>16 SHALL clamp to 16; a new k SHALL apply at the next FILT.
REQ-026 A trigger in the OUT cycle SHALL count as an overrun; a trigger in the first IDLE cycle SHALL be accepted.

Reset
REQ-027 a_reset SHALL asynchronously force: FSM=IDLE, acc/root/remainder/operand=0, all outputs 0, overrun_count=0, config fields=0, deci_clk history=0.
REQ-028 Reset mid-CALC SHALL abort without emitting tvalid; the first trigger after release SHALL start cleanly.

Structure
REQ-029 Package lck_ampl_pkg SHALL hold the width constants, the FSM state enum {IDLE, CALC, FILT, OUT}, and the config bit offsets.
REQ-030 The iterative root SHALL be a sub-module lck_isqrt_iter (start/operand in, done/root out); filter, FSM, and config SHALL stay in the top level.

Verification
REQ-031 A2=0 triggered -> raw=0, ampl=0, tvalid exactly at T+26.
REQ-032 A2=2^48-1 -> raw=0xFFFFFF; A2=1000000 -> raw=1000; A2=999999 -> raw=999.
REQ-033 Second trigger at T+10 -> overrun_count=1, first result intact at T+26; then clear strobe -> 0.
REQ-034 Enable=1, k=1; A2 sequence 1000000, 0, 0 -> ampl 1000 (preload), 500, 250.
REQ-035 a_reset pulsed at T+12 -> no tvalid, all outputs 0; new trigger A2=4 -> raw=2 after 26 cycles.
